// File: rtl/pwm_multi_ctrl_pkg.sv
// Shared types and constants for the multi-channel PWM block.
package pwm_multi_pkg;

  localparam int CH_MAX = 16;

  // Counting mode as carried in the shadow/active mode bit.
  localparam logic EDGE   = 1'b0;
  localparam logic CENTER = 1'b1;

  // Period counter state. IDLE holds the counter at zero.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_UP   = 2'd1,
    ST_DOWN = 2'd2
  } cnt_state_e;

endpackage

// File: rtl/pwm_multi_ctrl_if.sv
// Register-side / pin-side bundle of the PWM controller.
// The master drives configuration; the slave (the PWM block) drives the outputs.
interface pwm_multi_ctrl_if #(
  parameter int CH = 4,
  parameter int CW = 28
) ();

  logic             RUN;
  logic             LOAD;
  logic [CW-1:0]    PERIOD_IN;
  logic [CH*CW-1:0] DUTY_IN;
  logic             CENTER_IN;
  logic [CH-1:0]    CH_EN;
  logic [CH-1:0]    PWM_OUT;
  logic             PERIOD_END;
  logic             PEND;

  modport master (
    output RUN, LOAD, PERIOD_IN, DUTY_IN, CENTER_IN, CH_EN,
    input  PWM_OUT, PERIOD_END, PEND
  );

  modport slave (
    input  RUN, LOAD, PERIOD_IN, DUTY_IN, CENTER_IN, CH_EN,
    output PWM_OUT, PERIOD_END, PEND
  );

endinterface

// File: rtl/pwm_multi_ctrl_cmp.sv
// One PWM channel: duty compare against the shared counter, live enable,
// polarity and the output register. Inactive level equals POL.
module pwm_channel_cmp #(
  parameter int   CW  = 28,
  parameter logic POL = 1'b0
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic [CW-1:0] cnt,
  input  logic [CW-1:0] duty,
  input  logic          en,
  input  logic          running,
  output logic          pwm_out
);

  logic active;

  // Unsigned compare: duty 0 never fires, duty >= period always fires.
  assign active = en & running & (cnt < duty);

  // Registered output, one cycle behind the counter value it reflects.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) pwm_out <= POL;
    else     pwm_out <= active ^ POL;
  end

endmodule

// File: rtl/pwm_multi_ctrl.sv
// Multi-channel PWM: a shared period counter (edge or centre aligned) feeds
// CH duty comparators. Period, duties and mode are double-buffered and only
// move from shadow to active at a period boundary (or while idle), so a
// reconfiguration never produces a truncated or stretched pulse.
module pwm_multi_ctrl
  import pwm_multi_pkg::*;
#(
  parameter int            CH       = 4,
  parameter int            CW       = 28,
  parameter logic [CH-1:0] POL_MASK = '0
) (
  input  logic              CLK,
  input  logic              RST,
  pwm_multi_ctrl_if.slave   bus
);

  localparam logic [CW-1:0] ONE = {{(CW-1){1'b0}}, 1'b1};

  cnt_state_e              state;
  logic [CW-1:0]           cnt;
  logic [CW-1:0]           act_p;
  logic [CW-1:0]           sh_p;
  logic [CH-1:0][CW-1:0]   act_duty;
  logic [CH-1:0][CW-1:0]   sh_duty;
  logic                    act_center;
  logic                    sh_center;
  logic                    pend;
  logic                    period_end;
  logic [CH-1:0]           pwm_q;

  logic running;
  logic last_up;
  logic boundary;
  logic apply;

  // A zero period parks the counter exactly like RUN=0.
  assign running = bus.RUN && (act_p != '0);

  // Top of the up-ramp; >= keeps a stray count from running away.
  assign last_up = (cnt >= act_p - ONE);

  // Last cycle of a period: edge wraps at P-1, centre ends on the down-ramp at 0.
  assign boundary = running &&
                    ((act_center == CENTER) ? ((state == ST_DOWN) && (cnt == '0))
                                            : last_up);

  // Pending shadow is taken at a boundary, or immediately while idle.
  assign apply = pend && (boundary || !running);

  // Counter state machine plus shadow/active register bank.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      act_p      <= '0;
      act_duty   <= '0;
      act_center <= EDGE;
      sh_p       <= '0;
      sh_duty    <= '0;
      sh_center  <= EDGE;
      pend       <= 1'b0;
      period_end <= 1'b0;
    end else begin
      // A LOAD coinciding with an apply lands in shadow after the old
      // shadow has been copied out, so it waits for the next boundary.
      if (bus.LOAD) begin
        sh_p      <= bus.PERIOD_IN;
        sh_duty   <= bus.DUTY_IN;
        sh_center <= bus.CENTER_IN;
      end
      pend <= bus.LOAD | (pend & ~apply);

      if (apply) begin
        act_p      <= sh_p;
        act_duty   <= sh_duty;
        act_center <= sh_center;
      end

      period_end <= boundary;

      if (!running) begin
        state <= ST_IDLE;
        cnt   <= '0;
      end else if (boundary) begin
        state <= ST_UP;
        cnt   <= '0;
      end else begin
        case (state)
          ST_DOWN: cnt <= cnt - ONE;
          default: begin
            // IDLE behaves as UP at zero so a restart counts immediately.
            if ((act_center == CENTER) && last_up) begin
              state <= ST_DOWN;
            end else begin
              state <= ST_UP;
              cnt   <= cnt + ONE;
            end
          end
        endcase
      end
    end
  end

  for (genvar i = 0; i < CH; i++) begin : g_ch
    pwm_channel_cmp #(
      .CW  (CW),
      .POL (POL_MASK[i])
    ) u_cmp (
      .CLK     (CLK),
      .RST     (RST),
      .cnt     (cnt),
      .duty    (act_duty[i]),
      .en      (bus.CH_EN[i]),
      .running (running),
      .pwm_out (pwm_q[i])
    );
  end

  assign bus.PWM_OUT    = pwm_q;
  assign bus.PERIOD_END = period_end;
  assign bus.PEND       = pend;

endmodule

// File: tb/tb_pwm_multi_ctrl.sv
// Directed bench for pwm_multi_ctrl: CH=4, CW=8, channel 1 active-low.
module tb_pwm_multi_ctrl;
  import pwm_multi_pkg::*;

  localparam int            CH  = 4;
  localparam int            CW  = 8;
  localparam logic [CH-1:0] POL = 4'b0010;

  logic CLK = 1'b0;
  logic RST = 1'b1;

  always #5 CLK = ~CLK;

  pwm_multi_ctrl_if #(.CH(CH), .CW(CW)) bus ();

  pwm_multi_ctrl #(.CH(CH), .CW(CW), .POL_MASK(POL)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  int            n_tests = 0;
  int            n_fail  = 0;
  int            hi [CH];
  int            pe_cnt;
  logic [31:0]   hist0;
  logic [CH-1:0] first_act;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge CLK);
  endtask

  function automatic logic [CH*CW-1:0] dv(input logic [CW-1:0] d3, d2, d1, d0);
    return {d3, d2, d1, d0};
  endfunction

  task automatic set_load(input logic [CW-1:0] p, input logic [CH*CW-1:0] d, input logic c);
    bus.LOAD      = 1'b1;
    bus.PERIOD_IN = p;
    bus.DUTY_IN   = d;
    bus.CENTER_IN = c;
  endtask

  // Sample n cycles: per-channel active counts (polarity removed), PERIOD_END
  // count, ch0 activity history and the first sample.
  task automatic measure(input int n);
    logic [CH-1:0] act;
    pe_cnt = 0;
    hist0  = '0;
    for (int i = 0; i < CH; i++) hi[i] = 0;
    for (int k = 0; k < n; k++) begin
      step();
      act = bus.PWM_OUT ^ POL;
      if (k == 0) first_act = act;
      for (int i = 0; i < CH; i++) if (act[i]) hi[i]++;
      if (bus.PERIOD_END) pe_cnt++;
      if (k < 32) hist0[k] = act[0];
    end
  endtask

  task automatic wait_pe(input string tag, input int max);
    logic seen;
    seen = 1'b0;
    for (int k = 0; k < max && !seen; k++) begin
      step();
      seen = bus.PERIOD_END;
    end
    chk(tag, seen, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [CH-1:0] a;
    int            c;

    bus.RUN = 1'b0; bus.LOAD = 1'b0; bus.PERIOD_IN = '0;
    bus.DUTY_IN = '0; bus.CENTER_IN = EDGE; bus.CH_EN = 4'hF;

    // Reset state
    step(); step();
    chk("rst_pwm", bus.PWM_OUT, POL);
    chk("rst_pend", bus.PEND, 1'b0);
    chk("rst_pe", bus.PERIOD_END, 1'b0);
    chk("rst_cnt", dut.cnt, 0);
    RST = 1'b0;

    // Edge P=10, duties 0/3/10/15, loaded while idle
    set_load(8'd10, dv(8'd15, 8'd10, 8'd3, 8'd0), EDGE);
    step(); bus.LOAD = 1'b0;
    chk("idle_pend_rise", bus.PEND, 1'b1);
    step();
    chk("idle_pend_fall", bus.PEND, 1'b0);
    chk("idle_no_pe", bus.PERIOD_END, 1'b0);
    bus.RUN = 1'b1;
    wait_pe("e_wait_pe", 30);
    chk("e_pwm_at_pe", bus.PWM_OUT, 4'b1110);
    measure(20);
    chk("e_first", first_act ^ POL, 4'b1100);
    chk("e_hi0", hi[0], 0);
    chk("e_hi1", hi[1], 6);
    chk("e_hi2", hi[2], 20);
    chk("e_hi3", hi[3], 20);
    chk("e_pe", pe_cnt, 2);

    // Centre P=8, duties 2/2/0/8 via shadow
    set_load(8'd8, dv(8'd8, 8'd0, 8'd2, 8'd2), CENTER);
    step(); bus.LOAD = 1'b0;
    chk("c_pend", bus.PEND, 1'b1);
    wait_pe("c_wait_pe", 20);
    chk("c_pend_clr", bus.PEND, 1'b0);
    measure(32);
    chk("c_hi0", hi[0], 8);
    chk("c_hi1", hi[1], 8);
    chk("c_hi2", hi[2], 0);
    chk("c_hi3", hi[3], 32);
    chk("c_pe", pe_cnt, 2);
    chk("c_shape", hist0, 32'hC003C003);

    // Edge P=10 duty 3, then LOAD duty 7 at CNT=4
    set_load(8'd10, dv(8'd3, 8'd3, 8'd3, 8'd3), EDGE);
    step(); bus.LOAD = 1'b0;
    wait_pe("m_wait_pe", 40);
    c = 0;
    for (int k = 1; k <= 10; k++) begin
      if (k == 5) set_load(8'd10, dv(8'd7, 8'd7, 8'd7, 8'd7), EDGE);
      step();
      bus.LOAD = 1'b0;
      a = bus.PWM_OUT ^ POL;
      if (a[0]) c++;
      if (k == 5) chk("m_pend_set", bus.PEND, 1'b1);
      if (k == 9) chk("m_pend_hold", bus.PEND, 1'b1);
    end
    chk("m_old_duty", c, 3);
    chk("m_pe", bus.PERIOD_END, 1'b1);
    chk("m_pend_clr", bus.PEND, 1'b0);
    measure(10);
    chk("m_new_duty", hi[0], 7);
    chk("m_new_pe", pe_cnt, 1);

    // Two LOADs in one period, second in the boundary cycle
    c = 0;
    for (int k = 1; k <= 10; k++) begin
      if (k == 2)  set_load(8'd10, dv(8'd5, 8'd5, 8'd5, 8'd5), EDGE);
      if (k == 10) set_load(8'd10, dv(8'd8, 8'd8, 8'd8, 8'd8), EDGE);
      step();
      bus.LOAD = 1'b0;
      a = bus.PWM_OUT ^ POL;
      if (a[0]) c++;
    end
    chk("t_cur_duty", c, 7);
    chk("t_pend_kept", bus.PEND, 1'b1);
    measure(10);
    chk("t_first_duty", hi[0], 5);
    chk("t_pend_clr", bus.PEND, 1'b0);
    bus.CH_EN = 4'b1101;
    measure(10);
    chk("t_second_duty", hi[0], 8);
    chk("t_dis_ch1", hi[1], 0);
    chk("t_ch3", hi[3], 8);

    // Asynchronous reset mid-period with a pending shadow
    set_load(8'd10, dv(8'd5, 8'd5, 8'd5, 8'd5), EDGE);
    step(); bus.LOAD = 1'b0;
    step(); step();
    chk("r_pre_pend", bus.PEND, 1'b1);
    chk("r_pre_pwm", bus.PWM_OUT, 4'b1111);
    #2 RST = 1'b1;
    #1;
    chk("r_pwm", bus.PWM_OUT, POL);
    chk("r_pend", bus.PEND, 1'b0);
    chk("r_cnt", dut.cnt, 0);
    chk("r_pe", bus.PERIOD_END, 1'b0);
    step();
    RST = 1'b0;

    // Active P=0 after reset with RUN=1: idle
    bus.CH_EN = 4'hF;
    measure(20);
    chk("z_hi", hi[0] + hi[1] + hi[2] + hi[3], 0);
    chk("z_pe", pe_cnt, 0);
    chk("z_pwm", bus.PWM_OUT, POL);
    chk("z_cnt", dut.cnt, 0);

    // P=1 edge: every cycle is a boundary
    set_load(8'd1, dv(8'd0, 8'd1, 8'd1, 8'd0), EDGE);
    step(); bus.LOAD = 1'b0;
    chk("p1_pend", bus.PEND, 1'b1);
    step();
    chk("p1_pend_clr", bus.PEND, 1'b0);
    chk("p1_no_pe", bus.PERIOD_END, 1'b0);
    measure(10);
    chk("p1_pe", pe_cnt, 10);
    chk("p1_hi0", hi[0], 0);
    chk("p1_hi1", hi[1], 10);
    chk("p1_hi2", hi[2], 10);

    // RUN drop mid-period and restart
    set_load(8'd10, dv(8'd3, 8'd3, 8'd3, 8'd3), EDGE);
    step(); bus.LOAD = 1'b0;
    step();
    step(); step(); step();
    chk("s_cnt_run", dut.cnt, 3);
    bus.RUN = 1'b0;
    step();
    chk("s_cnt_stop", dut.cnt, 0);
    chk("s_pwm_stop", bus.PWM_OUT, POL);
    chk("s_pe_stop", bus.PERIOD_END, 1'b0);
    step();
    bus.RUN = 1'b1;
    step();
    chk("s_cnt_restart", dut.cnt, 1);
    chk("s_pe_restart", bus.PERIOD_END, 1'b0);
    chk("s_pwm_restart", bus.PWM_OUT, 4'b1101);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pwm_multi_ctrl.md
# pwm_multi_ctrl

Parametrised multi-channel PWM generator: one shared period counter drives CH independent duty comparators, with edge- or centre-aligned counting, per-channel polarity, and double-buffered (shadow) period/duty registers that take effect only at a period boundary so outputs never glitch on reconfiguration. It sits between the soft-CPU PIO/register outputs (period, duty, control) and the board pins (LEDs, motor/servo drivers), and supersedes the single-channel fixed-width PWM counter.

## Interface
- CH, default 4: number of PWM channels (1..16).
- CW, default 28: counter, period and duty width in bits.
- POL_MASK, default 0: CH-bit per-channel polarity; bit=1 means active-low output. Also defines the inactive/reset level.

- CLK  in  1  system clock; all logic on rising edge.
- RST  in  1  asynchronous, active-high reset.
- RUN  in  1  global counter enable.
- LOAD  in  1  one-cycle strobe; captures PERIOD_IN, DUTY_IN, CENTER_IN into shadow registers.
- PERIOD_IN  in  CW  new period P.
- DUTY_IN  in  CH*CW  new duties, channel i in bits [i*CW +: CW].
- CENTER_IN  in  1  new mode: 0 = edge-aligned, 1 = centre-aligned.
- CH_EN  in  CH  per-channel output enable (live, not shadowed).
- PWM_OUT  out  CH  registered PWM outputs.
- PERIOD_END  out  1  one-cycle pulse at start of each new period.
- PEND  out  1  shadow loaded, not yet applied.

## Operation
- Reset: counter CNT=0, direction UP, active P/duties/mode=0, shadow=0, PEND=0, PERIOD_END=0, PWM_OUT=POL_MASK (all inactive).
- Counter states: IDLE (RUN=0 or active P=0; CNT held 0), UP, DOWN (centre only).
- Edge mode: UP counts 0..P-1, wraps to 0. Boundary cycle = CNT==P-1.
- Centre mode: UP 0..P-1, DOWN P-1..0 (each end value held two consecutive cycles), period 2P cycles. Boundary cycle = DOWN with CNT==0.
- P=1 edge: CNT stays 0, every cycle is a boundary. P=0: IDLE regardless of RUN.
- Compare: raw_i = (CNT < duty_i), unsigned CW-bit. duty_i=0 → 0%; duty_i>=P → 100%.
- PWM_OUT[i] = (CH_EN[i] & running & raw_i) XOR POL_MASK[i]; disabled or IDLE → inactive level.
- LOAD: shadow <= inputs, PEND <= 1. Later LOAD before apply overwrites shadow (last wins).
- Apply: in boundary cycle with PEND=1, active <= shadow, PEND <= 0, CNT <= 0, direction <= UP. If IDLE, apply occurs the cycle after LOAD.
- LOAD in a boundary cycle: the previous shadow (if PEND) is applied; the new value is captured and applied at the next boundary.
- RUN 1→0 mid-period: CNT forced 0, direction UP next cycle; RUN 0→1 starts at CNT=0 with no PERIOD_END for the start.
- Mode change applies only via shadow at boundary; never mid-period.

## Timing
- PWM_OUT latency: 1 cycle from CNT value to output.
- PERIOD_END: registered, high the cycle after each boundary (aligned with CNT==0 of the new period); not asserted in IDLE.
- PEND rises the cycle after LOAD, falls the cycle after the applying boundary.
- New duty first visible on PWM_OUT 1 cycle after PERIOD_END.
- RST is asynchronous on assert; deassertion is externally synchronised to CLK.

## Structure
- Package pwm_multi_pkg: counter-state enum (IDLE, UP, DOWN), mode constants EDGE=0/CENTER=1, CH_MAX=16.
- Sub-module pwm_channel_cmp: one channel's compare, enable, polarity and output register; CH instances via generate. Counter, shadow logic and state machine in the top.

## Test plan
- CH=4, CW=8, P=10 edge, duties 0/3/10/15, all enabled → outputs high 0/3/10/10 of every 10 cycles; PERIOD_END every 10 cycles.
- Centre mode P=8, duty 2 → 4-cycle high pulse centred in a 16-cycle period; PERIOD_END every 16 cycles.
- Running P=10 duty 3, LOAD duty 7 at CNT=4 → current period keeps 3, PEND=1 until boundary, next period high 7 cycles.
- Two LOADs (duty 5, then 8) in one period, second at CNT=P-1 → next period uses 5, following period uses 8.
- POL_MASK=4'b0010, CH_EN[1]=0 → PWM_OUT[1] held 1; RST asserted mid-period → PWM_OUT=4'b0010, CNT=0, PEND=0 immediately.
- P=0 with RUN=1 → IDLE, all outputs inactive, no PERIOD_END; P=1 edge → PERIOD_END every cycle.
